// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared widths, defaults and state encoding for the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    localparam int                c_XLEN      = 16;
    localparam logic [c_XLEN-1:0] c_NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        ST_BUSY   = 2'd0,
        ST_SQUASH = 2'd1,
        ST_READY  = 2'd2,
        ST_FAULT  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_if
// Description : Instruction memory req/ack bus between fetch unit and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic              imem_req;
    logic [c_XLEN-1:0] imem_addr;
    logic              imem_ack;
    logic [c_XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : fetch_timeout_counter
// Description : Counts stalled fetch cycles; flags the cycle that hits TIMEOUT.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);

    localparam int unsigned    c_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_W-1:0] c_LIMIT = (TIMEOUT > 0) ? c_W'(TIMEOUT - 1) : '0;

    logic [c_W-1:0] r_count;

    // Expired fires on the stalled cycle whose increment would reach TIMEOUT.
    assign o_expired = (TIMEOUT != 0) && i_enable && (r_count == c_LIMIT);

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Program counter, imem req/ack fetch, branch squash and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [c_XLEN-1:0] RESET_PC  = 16'h0000,
    parameter logic [c_XLEN-1:0] NOP_INSTR = c_NOP_INSTR,
    parameter int unsigned       TIMEOUT   = 255
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              program_counter_increment,
    input  wire logic              branch_valid,
    input  wire logic [c_XLEN-1:0] branch_target,
    instruction_fetch_if.master    imem,
    output logic [c_XLEN-1:0]      current_instruction,
    output logic                   instruction_valid,
    output logic [c_XLEN-1:0]      program_counter,
    output logic                   fetch_error
);

    fetch_state_t      r_state;
    logic [c_XLEN-1:0] r_pc;
    logic [c_XLEN-1:0] r_pending;
    logic              r_req;
    logic [c_XLEN-1:0] r_instr;
    logic              r_valid;
    logic              r_error;

    logic w_clear;
    logic w_enable;
    logic w_expired;

    assign imem.imem_req       = r_req;
    assign imem.imem_addr      = r_pc;
    assign current_instruction = r_instr;
    assign instruction_valid   = r_valid;
    assign program_counter     = r_pc;
    assign fetch_error         = r_error;

    // Timer restarts whenever a new fetch (or squash wait) begins.
    always_comb begin
        w_clear  = 1'b0;
        w_enable = 1'b0;
        case (r_state)
            ST_BUSY: begin
                w_clear  = imem.imem_ack || branch_valid;
                w_enable = !imem.imem_ack;
            end
            ST_SQUASH: begin
                w_clear  = imem.imem_ack;
                w_enable = !imem.imem_ack;
            end
            ST_READY: w_clear = 1'b1;
            default:  w_clear = 1'b0;
        endcase
    end

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_enable  (w_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_BUSY;
            r_pc      <= RESET_PC;
            r_pending <= RESET_PC;
            r_req     <= 1'b1;
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                ST_BUSY: begin
                    if (imem.imem_ack && branch_valid) begin
                        r_pc <= branch_target;
                    end else if (imem.imem_ack) begin
                        r_state <= ST_READY;
                        r_req   <= 1'b0;
                        r_instr <= imem.imem_rdata;
                        r_valid <= 1'b1;
                    end else if (w_expired) begin
                        r_state <= ST_FAULT;
                        r_req   <= 1'b0;
                        r_error <= 1'b1;
                    end else if (branch_valid) begin
                        r_state   <= ST_SQUASH;
                        r_pending <= branch_target;
                    end
                end
                ST_SQUASH: begin
                    // The in-flight word belongs to the old path and is dropped.
                    if (imem.imem_ack) begin
                        r_state <= ST_BUSY;
                        r_pc    <= branch_valid ? branch_target : r_pending;
                    end else if (w_expired) begin
                        r_state <= ST_FAULT;
                        r_req   <= 1'b0;
                        r_error <= 1'b1;
                    end else if (branch_valid) begin
                        r_pending <= branch_target;
                    end
                end
                ST_READY: begin
                    if (branch_valid) begin
                        r_state <= ST_BUSY;
                        r_pc    <= branch_target;
                        r_req   <= 1'b1;
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end else if (program_counter_increment) begin
                        r_state <= ST_BUSY;
                        r_pc    <= r_pc + 1'b1;
                        r_req   <= 1'b1;
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_instr <= NOP_INSTR;
                    r_valid <= 1'b0;
                    r_error <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Scoreboard bench for instruction_fetch with a scripted memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        inc       = 1'b0;
    logic        br_valid  = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] cur_instr;
    logic [15:0] pc_out;
    logic        instr_valid;
    logic        fetch_err;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    instruction_fetch_if ifc ();

    instruction_fetch #(
        .RESET_PC  (16'h0000),
        .NOP_INSTR (16'h0000),
        .TIMEOUT   (4)
    ) dut (
        .clock                     (clk),
        .reset                     (reset),
        .program_counter_increment (inc),
        .branch_valid              (br_valid),
        .branch_target             (br_target),
        .imem                      (ifc.master),
        .current_instruction       (cur_instr),
        .instruction_valid         (instr_valid),
        .program_counter           (pc_out),
        .fetch_error               (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory side: ack after 'delay' cycles, queueing the word if it should surface.
    task automatic serve(input int delay, input logic [15:0] data, input bit expect_valid);
        repeat (delay) tick();
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = data;
        if (expect_valid) exp_q.push_back(data);
        tick();
        ifc.imem_ack   = 1'b0;
        ifc.imem_rdata = 16'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_asserts++;
        if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_req: req=%b addr=%h, expected 1/0000", ifc.imem_req, ifc.imem_addr);
        end
        n_asserts++;
        if (instr_valid !== 1'b0 || cur_instr !== 16'h0000 || fetch_err !== 1'b0 || pc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b instr=%h err=%b pc=%h, expected 0/0000/0/0000",
                     instr_valid, cur_instr, fetch_err, pc_out);
        end
        reset = 1'b0;
        serve(2, 16'h1234, 1'b1);
        n_asserts++;
        exp_w = exp_q.pop_front();
        if (instr_valid !== 1'b1 || cur_instr !== exp_w || pc_out !== 16'h0000 || ifc.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL first_word: valid=%b instr=%h pc=%h req=%b, expected 1/%h/0000/0",
                     instr_valid, cur_instr, pc_out, ifc.imem_req, exp_w);
        end
    endtask

    task automatic test_increment();
        br_valid = 1'b1; br_target = 16'h0005;
        tick();
        br_valid = 1'b0;
        serve(1, 16'hA005, 1'b1);
        n_asserts++;
        exp_w = exp_q.pop_front();
        if (instr_valid !== 1'b1 || cur_instr !== exp_w || pc_out !== 16'h0005) begin
            n_fail++;
            $display("FAIL word_at_5: valid=%b instr=%h pc=%h, expected 1/%h/0005", instr_valid, cur_instr, pc_out, exp_w);
        end
        inc = 1'b1;
        tick();
        inc = 1'b0;
        n_asserts++;
        if (instr_valid !== 1'b0 || cur_instr !== 16'h0000 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0006) begin
            n_fail++;
            $display("FAIL inc_req: valid=%b instr=%h req=%b addr=%h, expected 0/0000/1/0006",
                     instr_valid, cur_instr, ifc.imem_req, ifc.imem_addr);
        end
        // Increment while nothing is valid must not move the PC.
        inc = 1'b1;
        tick();
        inc = 1'b0;
        n_asserts++;
        if (ifc.imem_addr !== 16'h0006) begin
            n_fail++;
            $display("FAIL inc_ignored: addr=%h, expected 0006", ifc.imem_addr);
        end
        serve(0, 16'hA006, 1'b1);
        n_asserts++;
        exp_w = exp_q.pop_front();
        if (instr_valid !== 1'b1 || cur_instr !== exp_w || pc_out !== 16'h0006) begin
            n_fail++;
            $display("FAIL word_at_6: valid=%b instr=%h pc=%h, expected 1/%h/0006", instr_valid, cur_instr, pc_out, exp_w);
        end
    endtask

    task automatic test_branch_squash();
        inc = 1'b1;
        tick();
        inc = 1'b0;
        br_valid = 1'b1; br_target = 16'h0040;
        tick();
        br_valid = 1'b0;
        n_asserts++;
        if (ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0007 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_hold: req=%b addr=%h valid=%b, expected 1/0007/0", ifc.imem_req, ifc.imem_addr, instr_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_asserts++;
            if (instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL squash_wait%0d: valid=%b, expected 0", i, instr_valid);
            end
        end
        serve(0, 16'hDEAD, 1'b0);
        n_asserts++;
        if (instr_valid !== 1'b0 || cur_instr !== 16'h0000 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0040) begin
            n_fail++;
            $display("FAIL squash_redirect: valid=%b instr=%h req=%b addr=%h, expected 0/0000/1/0040",
                     instr_valid, cur_instr, ifc.imem_req, ifc.imem_addr);
        end
        serve(1, 16'hBEEF, 1'b1);
        n_asserts++;
        exp_w = exp_q.pop_front();
        if (instr_valid !== 1'b1 || cur_instr !== exp_w || pc_out !== 16'h0040) begin
            n_fail++;
            $display("FAIL word_at_40: valid=%b instr=%h pc=%h, expected 1/%h/0040", instr_valid, cur_instr, pc_out, exp_w);
        end
    endtask

    task automatic test_branch_with_ack();
        inc = 1'b1;
        tick();
        inc = 1'b0;
        br_valid = 1'b1; br_target = 16'h0080;
        ifc.imem_ack = 1'b1; ifc.imem_rdata = 16'hBAD1;
        tick();
        br_valid = 1'b0; ifc.imem_ack = 1'b0;
        n_asserts++;
        if (instr_valid !== 1'b0 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0080) begin
            n_fail++;
            $display("FAIL br_ack_redirect: valid=%b req=%b addr=%h, expected 0/1/0080", instr_valid, ifc.imem_req, ifc.imem_addr);
        end
        serve(0, 16'h5A5A, 1'b1);
        n_asserts++;
        exp_w = exp_q.pop_front();
        if (instr_valid !== 1'b1 || cur_instr !== exp_w || pc_out !== 16'h0080) begin
            n_fail++;
            $display("FAIL word_at_80: valid=%b instr=%h pc=%h, expected 1/%h/0080", instr_valid, cur_instr, pc_out, exp_w);
        end
    endtask

    task automatic test_branch_priority();
        br_valid = 1'b1; br_target = 16'h0100; inc = 1'b1;
        tick();
        br_valid = 1'b0; inc = 1'b0;
        n_asserts++;
        if (ifc.imem_addr !== 16'h0100 || ifc.imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL br_priority: addr=%h req=%b valid=%b, expected 0100/1/0", ifc.imem_addr, ifc.imem_req, instr_valid);
        end
        serve(2, 16'hC0DE, 1'b1);
        n_asserts++;
        exp_w = exp_q.pop_front();
        if (instr_valid !== 1'b1 || cur_instr !== exp_w || pc_out !== 16'h0100) begin
            n_fail++;
            $display("FAIL word_at_100: valid=%b instr=%h pc=%h, expected 1/%h/0100", instr_valid, cur_instr, pc_out, exp_w);
        end
    endtask

    task automatic test_wrap();
        br_valid = 1'b1; br_target = 16'hFFFF;
        tick();
        br_valid = 1'b0;
        serve(0, 16'h1111, 1'b1);
        n_asserts++;
        exp_w = exp_q.pop_front();
        if (instr_valid !== 1'b1 || cur_instr !== exp_w || pc_out !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL word_at_ffff: valid=%b instr=%h pc=%h, expected 1/%h/ffff", instr_valid, cur_instr, pc_out, exp_w);
        end
        serve(0, 16'h9999, 1'b0);
        n_asserts++;
        if (instr_valid !== 1'b1 || cur_instr !== 16'h1111 || ifc.imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_ack_ignored: valid=%b instr=%h req=%b, expected 1/1111/0", instr_valid, cur_instr, ifc.imem_req);
        end
        inc = 1'b1;
        tick();
        inc = 1'b0;
        n_asserts++;
        if (ifc.imem_addr !== 16'h0000 || pc_out !== 16'h0000 || ifc.imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL pc_wrap: addr=%h pc=%h req=%b, expected 0000/0000/1", ifc.imem_addr, pc_out, ifc.imem_req);
        end
        serve(0, 16'h2222, 1'b1);
        n_asserts++;
        exp_w = exp_q.pop_front();
        if (instr_valid !== 1'b1 || cur_instr !== exp_w || pc_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL word_after_wrap: valid=%b instr=%h pc=%h, expected 1/%h/0000", instr_valid, cur_instr, pc_out, exp_w);
        end
    endtask

    task automatic test_timeout();
        inc = 1'b1;
        tick();
        inc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_asserts++;
            if (fetch_err !== 1'b0 || ifc.imem_req !== 1'b1) begin
                n_fail++;
                $display("FAIL stall%0d: err=%b req=%b, expected 0/1", i, fetch_err, ifc.imem_req);
            end
        end
        tick();
        n_asserts++;
        if (fetch_err !== 1'b1 || ifc.imem_req !== 1'b0 || instr_valid !== 1'b0 || cur_instr !== 16'h0000) begin
            n_fail++;
            $display("FAIL timeout_fault: err=%b req=%b valid=%b instr=%h, expected 1/0/0/0000",
                     fetch_err, ifc.imem_req, instr_valid, cur_instr);
        end
        serve(1, 16'h7777, 1'b0);
        n_asserts++;
        if (fetch_err !== 1'b1 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_sticky: err=%b valid=%b, expected 1/0", fetch_err, instr_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_asserts++;
        if (fetch_err !== 1'b0 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL fault_reset: err=%b req=%b addr=%h, expected 0/1/0000", fetch_err, ifc.imem_req, ifc.imem_addr);
        end
        // Ack on the last allowed stalled cycle beats the timeout.
        serve(3, 16'h3333, 1'b1);
        n_asserts++;
        exp_w = exp_q.pop_front();
        if (instr_valid !== 1'b1 || cur_instr !== exp_w || fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_wins: valid=%b instr=%h err=%b, expected 1/%h/0", instr_valid, cur_instr, fetch_err, exp_w);
        end
    endtask

    initial begin
        ifc.imem_ack   = 1'b0;
        ifc.imem_rdata = 16'h0000;
        test_reset();
        test_increment();
        test_branch_squash();
        test_branch_with_ack();
        test_branch_priority();
        test_wrap();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
